ysyx_22050598_mdu: RTL and testbench

//  Multi-cycle RV64M multiply/divide unit beside the execute stage. Executes
//  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their W forms.

---
 rtl/ysyx_22050598_mdu_pkg.sv | 37 +++
 rtl/ysyx_22050598_mdu_if.sv | 31 +++
 rtl/ysyx_22050598_mdu_div_step.sv | 32 +++
 rtl/ysyx_22050598_mdu.sv | 173 +++++++++++++++++
 tb/tb_ysyx_22050598_mdu.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050598_mdu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050598_mdu_pkg
// Shared definitions for the RV64M multiply/divide unit:
//   - mdu_funct3_e : M-extension funct3 encodings (MUL .. REMU)
//   - mdu_state_e  : sequencer states (IDLE -> CALC -> DONE)
//   - src1_signed / src2_signed : which operands an op treats as signed
// ---------------------------------------------------------------------------
package ysyx_22050598_mdu_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } mdu_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    // MUL keeps only the low half of the product, which is identical for
    // signed and unsigned operands, so it runs as an unsigned multiply.
    function automatic logic src1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic src2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/ysyx_22050598_mdu_if.sv
// ---------------------------------------------------------------------------
// ysyx_22050598_mdu_if
// Request/response bus between the execute stage (master) and the MDU (slave).
//   request : in_valid, in_ready, funct3, is_word, src1, src2, rd_in
//   response: out_valid, out_ready, result, rd_out
// ---------------------------------------------------------------------------
interface ysyx_22050598_mdu_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic            is_word;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [4:0]      rd_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output in_valid, funct3, is_word, src1, src2, rd_in, out_ready,
        input  in_ready, out_valid, result, rd_out
    );

    modport slave (
        input  in_valid, funct3, is_word, src1, src2, rd_in, out_ready,
        output in_ready, out_valid, result, rd_out
    );
endinterface

// File: rtl/ysyx_22050598_mdu_div_step.sv
// ---------------------------------------------------------------------------
// ysyx_22050598_mdu_div_step
// One combinational restoring-division step on unsigned magnitudes.
//   rem_in  : partial remainder (always < divisor)
//   quo_in  : dividend bits still to consume (MSB first) / quotient bits so far
//   divisor : divisor magnitude (never zero here)
//   rem_out : partial remainder after this step
//   quo_out : quo_in shifted left with the new quotient bit in the LSB
// ---------------------------------------------------------------------------
module ysyx_22050598_mdu_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        // Because rem_in < divisor, shifted < 2*divisor: a non-negative
        // difference never reaches bit XLEN, so that bit is a pure borrow flag.
        fits    = ~diff[XLEN];
        rem_out = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_out = {quo_in[XLEN-2:0], fits};
    end
endmodule

// File: rtl/ysyx_22050598_mdu.sv
// ---------------------------------------------------------------------------
// ysyx_22050598_mdu
// Iterative RV64M multiply/divide unit (radix-2 shift-add multiply,
// restoring divide), one result bit per cycle.
//   clk   : clock
//   rst   : synchronous reset, active-high
//   flush : squash any op in flight; wins over a same-cycle accept/handshake
//   bus   : slave side of ysyx_22050598_mdu_if (valid/ready request and
//           response channels, funct3/is_word/src1/src2/rd_in, result/rd_out)
// ---------------------------------------------------------------------------
module ysyx_22050598_mdu
    import ysyx_22050598_mdu_pkg::*;
#(
    parameter  int XLEN  = 64,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    ysyx_22050598_mdu_if.slave bus
);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    // Replace bits above 31 with the sign (sgn=1) or zero (sgn=0) of bit 31.
    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
        return r;
    endfunction

    mdu_state_e        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3_q;
    logic              word_q;
    logic              neg_a_q, neg_b_q;
    logic [XLEN-1:0]   opnd_q;      // multiplicand, or divisor magnitude
    logic [2*XLEN-1:0] acc_q;       // product {hi, lo}, or divide {rem, quo}
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_q;

    logic accept;
    assign accept = bus.in_valid && (state == ST_IDLE) && !flush;

    // ---------------- operand preparation at capture ----------------
    logic             a_sgn, b_sgn, is_div, div_zero, div_ovf, min_a, special;
    logic             neg_a, neg_b;
    logic [XLEN-1:0]  op_a, op_b, mag_a, mag_b, special_raw, special_res, div_init;
    logic [CNT_W-1:0] n_iter;

    always_comb begin
        a_sgn    = src1_signed(bus.funct3);
        b_sgn    = src2_signed(bus.funct3);
        is_div   = bus.funct3[2];
        op_a     = bus.is_word ? ext32(bus.src1, a_sgn) : bus.src1;
        op_b     = bus.is_word ? ext32(bus.src2, b_sgn) : bus.src2;
        neg_a    = a_sgn & op_a[XLEN-1];
        neg_b    = b_sgn & op_b[XLEN-1];
        mag_a    = neg_a ? -op_a : op_a;
        mag_b    = neg_b ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        min_a    = bus.is_word ? (op_a[31:0] == 32'h8000_0000) : (op_a == MIN_VAL);
        div_ovf  = is_div && b_sgn && min_a && (op_b == '1);
        special  = div_zero || div_ovf;
        // funct3[1] selects remainder (REM/REMU) over quotient (DIV/DIVU).
        if (div_zero) special_raw = bus.funct3[1] ? op_a : '1;
        else          special_raw = bus.funct3[1] ? '0   : op_a;
        special_res = bus.is_word ? ext32(special_raw, 1'b1) : special_raw;
        // Word divides start with the 32-bit dividend in the top of the
        // quotient register so 32 steps consume exactly its bits.
        div_init = bus.is_word ? (mag_a << (XLEN - 32)) : mag_a;
        n_iter   = bus.is_word ? CNT_W'(32) : CNT_W'(XLEN);
    end

    // ---------------- iteration step and sign fix-up ----------------
    logic [XLEN-1:0]   addend, rem_step, quo_step;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next, step_next, prod_raw, prod_fix;
    logic [XLEN-1:0]   mul_res, quo_fix, rem_fix, div_res, raw_res, final_res;
    logic              sign_diff;

    ysyx_22050598_mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (acc_q[2*XLEN-1:XLEN]),
        .quo_in  (acc_q[XLEN-1:0]),
        .divisor (opnd_q),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_comb begin
        addend    = acc_q[0] ? opnd_q : '0;
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_next  = {rem_step, quo_step};
        step_next = f3_q[2] ? div_next : mul_next;
        sign_diff = neg_a_q ^ neg_b_q;
        // After only 32 steps the product still sits 32 bits up.
        prod_raw  = word_q ? (mul_next >> (XLEN - 32)) : mul_next;
        prod_fix  = sign_diff ? -prod_raw : prod_raw;
        mul_res   = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        quo_fix   = sign_diff ? -quo_step : quo_step;
        rem_fix   = neg_a_q ? -rem_step : rem_step;
        div_res   = f3_q[1] ? rem_fix : quo_fix;
        raw_res   = f3_q[2] ? div_res : mul_res;
        final_res = word_q ? ext32(raw_res, 1'b1) : raw_res;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (accept) state_next = special ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                if (cnt == CNT_W'(1)) state_next = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            f3_q     <= '0;
            word_q   <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            f3_q    <= bus.funct3;
            word_q  <= bus.is_word;
            rd_q    <= bus.rd_in;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            opnd_q  <= is_div ? mag_b : mag_a;
            acc_q   <= is_div ? {{XLEN{1'b0}}, div_init} : {{XLEN{1'b0}}, mag_b};
            cnt     <= special ? '0 : n_iter;
            if (special) result_q <= special_res;
        end else if (state == ST_CALC) begin
            acc_q <= step_next;
            cnt   <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) result_q <= final_res;
        end
    end

    assign bus.result = result_q;
    assign bus.rd_out = rd_q;

endmodule

// File: tb/tb_ysyx_22050598_mdu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050598_mdu
// Self-checking bench: a table of directed ops with hand-computed results and
// latencies, plus hand-written sequences for hold, flush and mid-op reset.
// ---------------------------------------------------------------------------
module tb_ysyx_22050598_mdu;
    import ysyx_22050598_mdu_pkg::*;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    logic clk, rst, flush;
    int   n_checks = 0;
    int   n_errors = 0;

    ysyx_22050598_mdu_if #(.XLEN(64)) bus ();

    ysyx_22050598_mdu #(.XLEN(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            step();
            guard++;
        end
        check("in_ready before send", {63'b0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.funct3   = f3;
        bus.is_word  = w;
        bus.src1     = a;
        bus.src2     = b;
        bus.rd_in    = rd;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Called just after the accept edge; lat counts the accept cycle as 1.
    task automatic wait_valid(output int lat, output logic busy_ready);
        lat        = 1;
        busy_ready = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) busy_ready = 1'b1;
            step();
            lat++;
        end
        if (bus.in_ready) busy_ready = 1'b1;
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        logic br;
        logic seen;

        vecs[0]  = '{F3_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
        vecs[1]  = '{F3_MULHU,  1'b0, ONES, 64'd2, 64'd1, 65};
        vecs[2]  = '{F3_MULHSU, 1'b0, ONES, 64'd2, ONES, 65};
        vecs[3]  = '{F3_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        vecs[4]  = '{F3_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65};
        vecs[5]  = '{F3_DIVU,   1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, 33};
        vecs[6]  = '{F3_DIV,    1'b0, 64'd123, 64'd0, ONES, 1};
        vecs[7]  = '{F3_REM,    1'b0, 64'd5, 64'd0, 64'd5, 1};
        vecs[8]  = '{F3_DIV,    1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1};
        vecs[9]  = '{F3_REM,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1};
        vecs[10] = '{F3_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
        vecs[11] = '{F3_MULH,   1'b0, 64'h8000_0000_0000_0000, 64'd2, ONES, 65};
        vecs[12] = '{F3_DIVU,   1'b0, 64'd100, 64'd7, 64'd14, 65};
        vecs[13] = '{F3_REMU,   1'b0, 64'd100, 64'd7, 64'd2, 65};
        vecs[14] = '{F3_DIV,    1'b1, 64'h1234_5678_FFFF_FFF9, 64'hDEAD_BEEF_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        vecs[15] = '{F3_REMU,   1'b1, 64'hAAAA_AAAA_0000_000B, 64'h5555_5555_0000_0003, 64'd2, 33};
        vecs[16] = '{F3_MULHU,  1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        vecs[17] = '{F3_DIV,    1'b1, 64'h0000_0000_FFFF_FFF9, 64'h0000_0001_0000_0000, ONES, 1};
        vecs[18] = '{F3_REM,    1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1};

        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.funct3 = 3'b000;
        bus.is_word = 1'b0;
        bus.src1 = '0;
        bus.src2 = '0;
        bus.rd_in = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        check("reset in_ready",  {63'b0, bus.in_ready},  64'd1);
        check("reset out_valid", {63'b0, bus.out_valid}, 64'd0);
        check("reset result",    bus.result,             64'd0);
        check("reset rd_out",    {59'b0, bus.rd_out},    64'd0);
        rst = 1'b0;
        step();

        // Each op is taken as soon as it is valid and the next one is sent in
        // the single idle cycle that follows, so the table also runs back-to-back.
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, 5'(i + 1));
            wait_valid(lat, br);
            check($sformatf("vec%0d result", i), bus.result, vecs[i].exp);
            check($sformatf("vec%0d rd_out", i), {59'b0, bus.rd_out}, 64'(i + 1));
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d in_ready while busy", i), {63'b0, br}, 64'd0);
            take();
            check($sformatf("vec%0d idle after take", i),
                  {63'b0, bus.in_ready & ~bus.out_valid}, 64'd1);
        end

        // Result held in DONE while out_ready is low; a new request is ignored.
        send(F3_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9);
        wait_valid(lat, br);
        bus.in_valid = 1'b1;
        bus.funct3   = F3_MUL;
        bus.src1     = 64'd3;
        bus.src2     = 64'd3;
        bus.rd_in    = 5'd3;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("hold%0d result", k), bus.result, ONES);
            check($sformatf("hold%0d rd_out", k), {59'b0, bus.rd_out}, 64'd9);
            check($sformatf("hold%0d valid/busy", k),
                  {62'b0, bus.out_valid, bus.in_ready}, 64'b10);
        end
        bus.in_valid = 1'b0;
        take();
        check("hold idle after take", {63'b0, bus.in_ready}, 64'd1);

        // Flush during CALC cycle 10.
        send(F3_MUL, 1'b0, 64'd3, 64'd5, 5'd7);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush calc in_ready", {63'b0, bus.in_ready}, 64'd1);
        seen = 1'b0;
        repeat (80) begin
            if (bus.out_valid) seen = 1'b1;
            step();
        end
        check("flush calc no out_valid", {63'b0, seen}, 64'd0);
        send(F3_DIVU, 1'b0, 64'd100, 64'd7, 5'd11);
        wait_valid(lat, br);
        check("post-flush result",  bus.result, 64'd14);
        check("post-flush rd_out",  {59'b0, bus.rd_out}, 64'd11);
        check("post-flush latency", 64'(lat), 64'd65);
        take();

        // Flush beats a same-cycle accept.
        bus.in_valid = 1'b1;
        bus.funct3   = F3_DIV;
        bus.src1     = 64'd1;
        bus.src2     = 64'd0;
        bus.rd_in    = 5'd4;
        flush        = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush vs accept in_ready",  {63'b0, bus.in_ready},  64'd1);
        check("flush vs accept out_valid", {63'b0, bus.out_valid}, 64'd0);

        // Flush in DONE drops the pending result.
        send(F3_DIV, 1'b0, 64'd1, 64'd0, 5'd12);
        wait_valid(lat, br);
        check("done result before flush", bus.result, ONES);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush done out_valid", {63'b0, bus.out_valid}, 64'd0);
        check("flush done in_ready",  {63'b0, bus.in_ready},  64'd1);

        // Reset in the middle of a multiply.
        send(F3_MULHU, 1'b0, ONES, 64'd2, 5'd13);
        repeat (5) step();
        rst = 1'b1;
        step();
        check("mid-op reset in_ready",  {63'b0, bus.in_ready},  64'd1);
        check("mid-op reset out_valid", {63'b0, bus.out_valid}, 64'd0);
        check("mid-op reset result",    bus.result,             64'd0);
        check("mid-op reset rd_out",    {59'b0, bus.rd_out},    64'd0);
        rst = 1'b0;
        step();
        send(F3_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd14);
        wait_valid(lat, br);
        check("post-reset result",  bus.result, 64'hFFFF_FFFF_FFFF_FFEB);
        check("post-reset latency", 64'(lat), 64'd65);
        take();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
